// File: rtl/marie_core.sv
// marie_core: multicycle accumulator CPU (4-bit opcode, direct/indirect/subroutine ISA).
// Drives a single-port synchronous RAM with one cycle of read latency.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mem_addr/mem_wdata    RAM address and write data (combinational from state)
//   mem_rdata             RAM read data, valid the cycle after a read request
//   mem_cs/mem_we/mem_oe  RAM strobes; all low while rst is high
//   in_data               Input-instruction source, sampled in dispatch
//   out_data/out_valid    last Output value and its one-cycle update pulse
//   retire                pulse in the final cycle of every instruction
//   halted                high from Halt until reset
//   pc, ac                architectural PC and AC for debug
module marie_core #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned RESET_PC   = 'h100
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  retire,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ac
);

  localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);

  typedef enum logic [3:0] {
    S_F0, S_F1, S_D, S_I0, S_I1, S_R0, S_R1, S_X, S_W, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_JNS   = 4'h0, OP_LOAD  = 4'h1, OP_STORE = 4'h2, OP_ADD    = 4'h3,
    OP_SUBT  = 4'h4, OP_INPUT = 4'h5, OP_OUT   = 4'h6, OP_HALT   = 4'h7,
    OP_SKIP  = 4'h8, OP_JUMP  = 4'h9, OP_CLEAR = 4'hA, OP_ADDI   = 4'hB,
    OP_JUMPI = 4'hC, OP_LOADI = 4'hD, OP_STOREI = 4'hE, OP_NOP   = 4'hF
  } opcode_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d, mar_q, mar_d;
  logic [DATA_WIDTH-1:0]   ac_q, ac_d, ir_q, ir_d, mbr_q, mbr_d, out_q, out_d;
  logic                    outv_q, outv_d;

  opcode_e                 op;
  logic [ADDR_WIDTH-1:0]   operand;
  logic                    ac_neg, ac_zero, skip;

  assign op      = opcode_e'(ir_q[DATA_WIDTH-1 -: 4]);
  assign operand = ir_q[ADDR_WIDTH-1:0];
  assign ac_neg  = ac_q[DATA_WIDTH-1];
  assign ac_zero = (ac_q == '0);

  // Condition field sits at IR[11:10] regardless of ADDR_WIDTH.
  always_comb begin
    unique case (ir_q[11:10])
      2'b00:   skip = ac_neg;
      2'b01:   skip = ac_zero;
      2'b10:   skip = !ac_neg && !ac_zero;
      default: skip = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_F0;
      pc_q    <= PC_RST;
      ac_q    <= '0;
      ir_q    <= '0;
      mbr_q   <= '0;
      mar_q   <= '0;
      out_q   <= '0;
      outv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ac_q    <= ac_d;
      ir_q    <= ir_d;
      mbr_q   <= mbr_d;
      mar_q   <= mar_d;
      out_q   <= out_d;
      outv_q  <= outv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ac_d      = ac_q;
    ir_d      = ir_q;
    mbr_d     = mbr_q;
    mar_d     = mar_q;
    out_d     = out_q;
    outv_d    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    retire    = 1'b0;

    unique case (state_q)
      S_F0: begin
        mem_addr = pc_q;
        mem_cs   = 1'b1;
        mem_oe   = 1'b1;
        state_d  = S_F1;
      end
      S_F1: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + 1'b1;
        state_d = S_D;
      end
      S_D: begin
        state_d = S_F0;
        unique case (op)
          OP_JNS, OP_STORE: begin
            mar_d   = operand;
            state_d = S_W;
          end
          OP_LOAD, OP_ADD, OP_SUBT: begin
            mar_d   = operand;
            state_d = S_R0;
          end
          OP_ADDI, OP_JUMPI, OP_LOADI, OP_STOREI: state_d = S_I0;
          OP_INPUT: begin ac_d = in_data;             retire = 1'b1; end
          OP_OUT:   begin out_d = ac_q; outv_d = 1'b1; retire = 1'b1; end
          OP_HALT:  begin state_d = S_HALT;            retire = 1'b1; end
          OP_SKIP:  begin
            if (skip) pc_d = pc_q + 1'b1;
            retire = 1'b1;
          end
          OP_JUMP:  begin pc_d = operand;              retire = 1'b1; end
          OP_CLEAR: begin ac_d = '0;                   retire = 1'b1; end
          default:  retire = 1'b1;
        endcase
      end
      S_I0: begin
        mem_addr = operand;
        mem_cs   = 1'b1;
        mem_oe   = 1'b1;
        state_d  = S_I1;
      end
      S_I1: begin
        if (op == OP_JUMPI) begin
          pc_d    = mem_rdata[ADDR_WIDTH-1:0];
          retire  = 1'b1;
          state_d = S_F0;
        end else begin
          mar_d   = mem_rdata[ADDR_WIDTH-1:0];
          state_d = (op == OP_STOREI) ? S_W : S_R0;
        end
      end
      S_R0: begin
        mem_addr = mar_q;
        mem_cs   = 1'b1;
        mem_oe   = 1'b1;
        state_d  = S_R1;
      end
      S_R1: begin
        mbr_d   = mem_rdata;
        state_d = S_X;
      end
      S_X: begin
        unique case (op)
          OP_ADD, OP_ADDI: ac_d = ac_q + mbr_q;
          OP_SUBT:         ac_d = ac_q - mbr_q;
          default:         ac_d = mbr_q;
        endcase
        retire  = 1'b1;
        state_d = S_F0;
      end
      S_W: begin
        mem_addr = mar_q;
        mem_cs   = 1'b1;
        mem_we   = 1'b1;
        if (op == OP_JNS) begin
          // Return address is the already-incremented PC; execution resumes after the stored word.
          mem_wdata = DATA_WIDTH'(pc_q);
          pc_d      = mar_q + 1'b1;
        end else begin
          mem_wdata = ac_q;
        end
        retire  = 1'b1;
        state_d = S_F0;
      end
      default: ;
    endcase

    // Reset dominates the combinational RAM strobes, so a write in progress is dropped.
    if (rst) begin
      mem_addr = '0;
      mem_cs   = 1'b0;
      mem_we   = 1'b0;
      mem_oe   = 1'b0;
      retire   = 1'b0;
    end
  end

  assign out_data  = out_q;
  assign out_valid = outv_q;
  assign halted    = (state_q == S_HALT);
  assign pc        = pc_q;
  assign ac        = ac_q;

endmodule

// File: tb/tb_marie_core.sv
// Self-checking bench for marie_core: ISA-level reference model run in lockstep
// with the core, directed programs from the test plan plus a random program,
// and a narrow-width instance for wrap behaviour.
`timescale 1ns/1ps
module tb_marie_core;

  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, in_data, out_data, ac;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_cs, mem_we, mem_oe, out_valid, retire, halted;
  logic [AW-1:0] pc;

  marie_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC('h100)) u_dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
    .retire(retire), .halted(halted), .pc(pc), .ac(ac)
  );

  // RAM with a backdoor port used only while the core is held in reset
  logic [DW-1:0] ram [4096] = '{default: '0};
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_cs && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_cs && mem_oe) mem_rdata <= ram[mem_addr];
  end

  // Narrow instance: 8-bit address, 12-bit data, reset PC at the top of memory
  logic         rst_s = 1'b1;
  logic [7:0]   mem_addr_s, pc_s;
  logic [11:0]  mem_wdata_s, out_data_s, ac_s;
  logic [11:0]  mem_rdata_s = '0;
  logic         mem_cs_s, mem_we_s, mem_oe_s, out_valid_s, retire_s, halted_s;

  marie_core #(.DATA_WIDTH(12), .ADDR_WIDTH(8), .RESET_PC('hFF)) u_dut_s (
    .clk(clk), .rst(rst_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
    .mem_rdata(mem_rdata_s), .mem_cs(mem_cs_s), .mem_we(mem_we_s), .mem_oe(mem_oe_s),
    .in_data(12'h000), .out_data(out_data_s), .out_valid(out_valid_s),
    .retire(retire_s), .halted(halted_s), .pc(pc_s), .ac(ac_s)
  );

  function automatic logic [11:0] rom_s(input logic [7:0] a);
    case (a)
      8'hFF:   rom_s = 12'hF00;  // NOP
      8'h00:   rom_s = 12'h110;  // Load 0x10
      8'h01:   rom_s = 12'h600;  // Output
      8'h02:   rom_s = 12'h311;  // Add 0x11
      8'h03:   rom_s = 12'h700;  // Halt
      8'h10:   rom_s = 12'hFFF;
      8'h11:   rom_s = 12'h001;
      default: rom_s = 12'h000;
    endcase
  endfunction

  always @(posedge clk) if (mem_cs_s && mem_oe_s) mem_rdata_s <= rom_s(mem_addr_s);

  // Reference model state
  logic [DW-1:0] rm [4096] = '{default: '0};
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_ac, m_out;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d; rm[a] = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic start_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_pc", pc, 12'h100);
    chk("rst_ac", ac, 0);
    chk("rst_halted", halted, 0);
    chk("rst_outs", {out_valid, retire, mem_cs, mem_we, mem_oe}, 0);
    chk("rst_out_data", out_data, 0);
    m_pc = 12'h100; m_ac = '0; m_out = '0;
  endtask

  // One instruction of the architectural model; returns expected cycle count.
  task automatic model_step(output int ecyc, output bit eout, output bit ehalt);
    logic [DW-1:0] ir;
    logic [AW-1:0] opr, ptr;
    bit sk;
    ir = rm[m_pc]; opr = ir[11:0]; m_pc = m_pc + 12'd1;
    eout = 0; ehalt = 0; ecyc = 3;
    case (ir[15:12])
      4'h0: begin rm[opr] = {4'h0, m_pc}; m_pc = opr + 12'd1; ecyc = 4; end
      4'h1: begin m_ac = rm[opr]; ecyc = 6; end
      4'h2: begin rm[opr] = m_ac; ecyc = 4; end
      4'h3: begin m_ac = m_ac + rm[opr]; ecyc = 6; end
      4'h4: begin m_ac = m_ac - rm[opr]; ecyc = 6; end
      4'h5: m_ac = in_data;
      4'h6: begin m_out = m_ac; eout = 1; end
      4'h7: ehalt = 1;
      4'h8: begin
        case (ir[11:10])
          2'b00:   sk = ($signed(m_ac) < 0);
          2'b01:   sk = (m_ac == 0);
          2'b10:   sk = ($signed(m_ac) > 0);
          default: sk = 0;
        endcase
        if (sk) m_pc = m_pc + 12'd1;
      end
      4'h9: m_pc = opr;
      4'hA: m_ac = '0;
      4'hB: begin ptr = rm[opr][11:0]; m_ac = m_ac + rm[ptr]; ecyc = 8; end
      4'hC: begin m_pc = rm[opr][11:0]; ecyc = 5; end
      4'hD: begin ptr = rm[opr][11:0]; m_ac = rm[ptr]; ecyc = 8; end
      4'hE: begin ptr = rm[opr][11:0]; rm[ptr] = m_ac; ecyc = 6; end
      default: ;
    endcase
  endtask

  task automatic wait_retire(output int cyc, output bit ok);
    cyc = 0; ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (retire) begin ok = 1; break; end
    end
  endtask

  // Runs the core and the model side by side until Halt or max_instr instructions.
  task automatic run_prog(input int max_instr);
    int ecyc, cyc;
    bit eout, ehalt, ok;
    for (int n = 0; n < max_instr; n++) begin
      in_data = DW'($urandom);
      model_step(ecyc, eout, ehalt);
      wait_retire(cyc, ok);
      if (!ok) begin
        chk("retire_timeout", retire, 1);
        return;
      end
      chk("cycles", cyc, ecyc);
      @(posedge clk); #1;
      chk("pc", pc, m_pc);
      chk("ac", ac, m_ac);
      chk("out_valid", out_valid, eout);
      if (eout) chk("out_data", out_data, m_out);
      if (ehalt) begin
        chk("halted", halted, 1);
        return;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit found;
    logic [AW-1:0] hold_pc;
    in_data = '0;

    // Multiply X*Y by repeated addition
    start_reset();
    poke(12'h100, 16'h110B); poke(12'h101, 16'h210D); poke(12'h102, 16'h110E);
    poke(12'h103, 16'h310C); poke(12'h104, 16'h210E); poke(12'h105, 16'h110D);
    poke(12'h106, 16'h310F); poke(12'h107, 16'h210D); poke(12'h108, 16'h8400);
    poke(12'h109, 16'h9102); poke(12'h10A, 16'h7000); poke(12'h10B, 16'h0005);
    poke(12'h10C, 16'h0007); poke(12'h10D, 16'h0000); poke(12'h10E, 16'h0000);
    poke(12'h10F, 16'hFFFF);
    rst = 1'b0;
    run_prog(100);
    chk("mul_halted", halted, 1);
    chk("mul_result", ram[12'h10E], 16'h0023);
    chk("mul_ctr", ram[12'h10D], 16'h0000);
    hold_pc = pc;
    repeat (3) @(posedge clk);
    #1;
    chk("halt_frozen_pc", pc, hold_pc);
    chk("halt_no_mem", {mem_cs, mem_we, mem_oe, retire}, 0);

    // Signed Skipcond
    start_reset();
    poke(12'h100, 16'h1110); poke(12'h101, 16'h8000); poke(12'h102, 16'h7000);
    poke(12'h103, 16'h8800); poke(12'h104, 16'h1111); poke(12'h105, 16'h8800);
    poke(12'h106, 16'h7000); poke(12'h107, 16'h8C00); poke(12'h108, 16'h7000);
    poke(12'h110, 16'h8000); poke(12'h111, 16'h0001);
    rst = 1'b0;
    run_prog(20);
    chk("skip_final_pc", pc, 12'h109);

    // JnS / JumpI subroutine round trip
    start_reset();
    for (int a = 'h100; a < 'h105; a++) poke(AW'(a), 16'hF000);
    poke(12'h105, 16'h0200); poke(12'h106, 16'h7000); poke(12'h201, 16'hC200);
    rst = 1'b0;
    run_prog(20);
    chk("jns_ret_addr", ram[12'h200], 16'h0106);
    chk("jns_final_pc", pc, 12'h107);

    // Indirect load/add/store
    start_reset();
    poke(12'h300, 16'h0310); poke(12'h310, 16'h0042);
    poke(12'h100, 16'hD300); poke(12'h101, 16'hB300); poke(12'h102, 16'hA000);
    poke(12'h103, 16'hE300); poke(12'h104, 16'h7000);
    rst = 1'b0;
    run_prog(20);
    chk("storei_target", ram[12'h310], 16'h0000);

    // Random straight-line program over a small data/pointer region
    start_reset();
    for (int i = 0; i < 16; i++) poke(AW'('h800 + i), DW'($urandom));
    for (int i = 0; i < 8; i++)  poke(AW'('h900 + i), DW'('h800 + $urandom_range(0, 15)));
    for (int i = 0; i < 120; i++) begin
      logic [DW-1:0] w;
      logic [DW-1:0] r16, r8, r4;
      r16 = DW'($urandom_range(0, 15));
      r8  = DW'($urandom_range(0, 7));
      r4  = DW'($urandom_range(0, 3));
      case ($urandom_range(0, 11))
        0:       w = 16'h1800 | r16;
        1:       w = 16'h2800 | r16;
        2:       w = 16'h3800 | r16;
        3:       w = 16'h4800 | r16;
        4:       w = 16'h5000;
        5:       w = 16'h6000;
        6:       w = 16'hA000;
        7:       w = 16'hF000;
        8:       w = 16'h8000 | (r4 << 10);
        9:       w = 16'hB900 | r8;
        10:      w = 16'hD900 | r8;
        default: w = 16'hE900 | r8;
      endcase
      poke(AW'('h100 + i), w);
    end
    poke(12'h178, 16'h7000); poke(12'h179, 16'h7000);
    rst = 1'b0;
    run_prog(200);
    chk("rand_halted", halted, 1);
    for (int i = 0; i < 16; i++) chk("rand_mem", ram['h800 + i], rm['h800 + i]);

    // Output, then reset landing on the write cycle of a Store
    start_reset();
    poke(12'h110, 16'h1234); poke(12'h120, 16'hABCD);
    poke(12'h100, 16'h1110); poke(12'h101, 16'h6000);
    poke(12'h102, 16'h2120); poke(12'h103, 16'h7000);
    rst = 1'b0;
    run_prog(2);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_we) begin found = 1; break; end
    end
    chk("store_w_seen", found, 1);
    rst = 1'b1;
    #1;
    chk("rst_w_we", mem_we, 0);
    chk("rst_w_cs", mem_cs, 0);
    @(posedge clk); #1;
    chk("rst_w_mem", ram[12'h120], 16'hABCD);
    chk("rst_w_pc", pc, 12'h100);
    chk("rst_w_halted", halted, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_fetch_addr", mem_addr, 12'h100);
    chk("first_fetch_strobes", {mem_cs, mem_we, mem_oe}, 3'b101);

    // Narrow instance: PC wrap and data wrap
    @(posedge clk); #1;
    chk("s_rst_pc", pc_s, 8'hFF);
    rst_s = 1'b0;
    @(negedge clk);
    chk("s_fetch_addr", mem_addr_s, 8'hFF);
    cyc = 1; found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cyc++;
      if (retire_s) begin found = 1; break; end
    end
    chk("s_nop_retire", found, 1);
    chk("s_nop_cycles", cyc, 3);
    @(posedge clk); #1;
    chk("s_pc_wrap", pc_s, 8'h00);
    for (int i = 0; i < 60; i++) begin
      if (halted_s) break;
      @(posedge clk); #1;
    end
    chk("s_halted", halted_s, 1);
    chk("s_ac_wrap", ac_s, 12'h000);
    chk("s_out_data", out_data_s, 12'hFFF);
    chk("s_pc_final", pc_s, 8'h04);
    chk("s_idle", {mem_cs_s, mem_we_s, mem_oe_s}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/marie_core.md
# marie_core

Synthesizable, parametrised multicycle accumulator CPU core implementing the full 4-bit-opcode accumulator ISA (direct, indirect and subroutine instructions) behind an FSM. It drives an external single-port synchronous RAM (read latency 1 cycle) and replaces testbench-sequenced fetch/execute with a self-contained controller. It sits between the RAM and the system bench; the ALU is internal.

## Interface
- DATA_WIDTH, 16, word width; must be >= ADDR_WIDTH+4
- ADDR_WIDTH, 12, address width; operand = IR[ADDR_WIDTH-1:0], opcode = IR[DATA_WIDTH-1:DATA_WIDTH-4]
- RESET_PC, 'h100, PC value after reset
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after a read request
- mem_cs, mem_we, mem_oe  out  1 each  RAM chip select, write enable, output enable
- in_data  in  DATA_WIDTH  Input-instruction source, sampled in DECODE
- out_data  out  DATA_WIDTH  last Output-instruction value (registered)
- out_valid  out  1  one-cycle pulse when out_data updates
- retire  out  1  one-cycle pulse in the final cycle of every instruction
- halted  out  1  high from Halt until reset
- pc, ac  out  ADDR_WIDTH, DATA_WIDTH  architectural PC and AC (debug)

## Operation
- Registers: PC, AC, IR, MBR, MAR. Reset: PC=RESET_PC, AC=IR=MBR=MAR=0, out_data=0, out_valid=retire=halted=0, state=F0. mem_cs/we/oe=0, mem_addr=0 while rst high (reset overrides any write in that cycle).
- Read request: mem_cs=1, mem_oe=1, mem_we=0. Write: mem_cs=1, mem_we=1, mem_oe=0. Idle states: all 0. mem_* are combinational from state/registers.
- States: F0 (read PC) -> F1 (IR<=rdata, PC<=PC+1) -> D (dispatch) -> {I0, I1, R0, R1, X, W, HALT}.
- I0: read operand. I1: MAR<=rdata[ADDR_WIDTH-1:0] (or PC<=rdata for JumpI, retire).
- R0: read MAR (direct ops load MAR<=operand in D). R1: MBR<=rdata. X: AC<=f(AC,MBR), retire.
- W: write mem_wdata to MAR, retire.
- Opcodes: 0 JnS: W writes PC (zero-extended) to operand, same cycle PC<=operand+1. 1 Load, 2 Store (W, data=AC), 3 Add, 4 Subt, 5 Input (AC<=in_data in D), 6 Output (out_data<=AC, out_valid in D), 7 Halt, 8 Skipcond, 9 Jump (PC<=operand in D), A Clear (AC<=0), B AddI, C JumpI, D LoadI, E StoreI, F NOP.
- Skipcond on IR[11:10] (fixed bits, independent of ADDR_WIDTH): 00 skip if AC signed <0, 01 if AC==0, 10 if AC signed >0, 11 never. Skip = PC<=PC+1.
- Arithmetic modulo 2^DATA_WIDTH, carry/overflow discarded. PC increments/skips wrap 2^ADDR_WIDTH-1 -> 0.
- HALT: halted=1, no memory access, registers frozen; only rst exits.

## Timing
- Cycles per instruction (F0 to retire inclusive): Jump/Clear/Skipcond/Input/Output/NOP 3; Store/JnS 4; Load/Add/Subt 6; JumpI 5; StoreI 6; LoadI/AddI 8. Halt: 3 cycles to assert halted (asserted entering HALT, retire in D).
- Next F0 immediately follows retire; no bubbles.
- rst sampled high in any state (incl. W, I1, HALT) -> reset values next cycle; first fetch read issued in the first cycle after rst falls.
- Store to the address being fetched next takes effect: write at W edge, F0 read next cycle returns new data.

## Test plan
- Multiply-by-addition loop (X=5 at 0x10B, Y=7 at 0x10C, ctr 0x10D, result 0x10E, one=0xFFFF), with Skipcond 01 and Jump -> halted=1, M[0x10E]=0x0023, M[0x10D]=0; retire count matches per-instruction cycle table.
- Skipcond signed: AC=0x8000 with 8000 skips, with 8800 does not; AC=0x0001 with 8800 skips; 8C00 never skips.
- JnS 0x200 from 0x105, then JumpI 0x200 -> M[0x200]=0x0106, PC resumes 0x106; JnS 4 cycles, JumpI 5.
- Indirect: M[0x300]=0x310, M[0x310]=0x0042; LoadI 0x300 -> AC=0x0042 in 8 cycles; StoreI 0x300 after Clear -> M[0x310]=0.
- Wrap/width: ADDR_WIDTH=8, DATA_WIDTH=12, RESET_PC='hFF, NOP at 0xFF -> next fetch 0x00; Add 0xFFF+1 -> AC=0.
- Reset during W cycle of Store -> mem_we=0 that cycle, memory unchanged, PC=RESET_PC, halted=0; Output of AC=0x1234 -> out_valid one cycle, out_data=0x1234.
